// File: rtl/mag_cmp_seq_pkg.sv
// Shared definitions for the sliced magnitude comparator.
// State encoding and index-width helper.
package mag_cmp_seq_pkg;

    typedef enum logic {
        MCS_IDLE = 1'b0,
        MCS_CMP  = 1'b1
    } mcs_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mag_chunk.sv
// Combinational unsigned compare of one operand slice.
// Exactly one of gt/eq/lt is high.
module mag_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator, one CHUNK-bit slice per clock,
// most significant slice first, exit on first unequal slice.
module mag_cmp_seq
    import mag_cmp_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("mag_cmp_seq: WIDTH must be a multiple of CHUNK");
    end

    mcs_state_t       state, state_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic [WIDTH-1:0] b_r, b_n;
    logic [IW-1:0]    idx, idx_n;
    logic             gt_n, eq_n, lt_n, done_n;

    logic [CHUNK-1:0] sa, sb;
    logic             c_gt, c_eq, c_lt;

    if (NCHUNK == 1) begin : g_one
        assign sa = a_r;
        assign sb = b_r;
    end else begin : g_mux
        logic [NCHUNK-1:0][CHUNK-1:0] a_s, b_s;
        assign a_s = a_r;
        assign b_s = b_r;
        assign sa  = a_s[idx];
        assign sb  = b_s[idx];
    end

    mag_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (sa),
        .b  (sb),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    assign busy = (state == MCS_CMP);

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state <= MCS_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_r   <= a_n;
            b_r   <= b_n;
            idx   <= idx_n;
            gt    <= gt_n;
            eq    <= eq_n;
            lt    <= lt_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        idx_n   = idx;
        gt_n    = gt;
        eq_n    = eq;
        lt_n    = lt;
        done_n  = 1'b0;
        unique case (state)
            MCS_IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps signed order onto unsigned
                    a_n            = a;
                    b_n            = b;
                    a_n[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    b_n[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    idx_n          = IW'(NCHUNK - 1);
                    state_n        = MCS_CMP;
                end
            end
            MCS_CMP: begin
                if (abort) begin
                    state_n = MCS_IDLE;
                end else if (!c_eq) begin
                    gt_n    = c_gt;
                    lt_n    = c_lt;
                    eq_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = MCS_IDLE;
                end else if (idx == '0) begin
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    eq_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = MCS_IDLE;
                end else begin
                    idx_n = idx - IW'(1);
                end
            end
            default: state_n = MCS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed and randomised checks of mag_cmp_seq in three slice widths.
// Expected values are hand-derived or come from a small reference model.
module tb_mag_cmp_seq;

    logic        clk = 1'b0;
    logic        resetl = 1'b0;
    logic        start = 1'b0, abort = 1'b0, signed_mode = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, gt, eq, lt;

    logic        sw_start = 1'b0, sw_sm = 1'b0;
    logic [31:0] sw_a = '0, sw_b = '0;
    logic        c1_busy, c1_done, c1_gt, c1_eq, c1_lt;
    logic        cw_busy, cw_done, cw_gt, cw_eq, cw_lt;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mag_cmp_seq #(.WIDTH(32), .CHUNK(4)) u_dut (
        .sys_clk(clk), .resetl(resetl), .start(start), .abort(abort),
        .signed_mode(signed_mode), .a(a), .b(b), .busy(busy),
        .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    mag_cmp_seq #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .sys_clk(clk), .resetl(resetl), .start(sw_start), .abort(1'b0),
        .signed_mode(sw_sm), .a(sw_a), .b(sw_b), .busy(c1_busy),
        .done(c1_done), .gt(c1_gt), .eq(c1_eq), .lt(c1_lt)
    );

    mag_cmp_seq #(.WIDTH(32), .CHUNK(32)) u_cw (
        .sys_clk(clk), .resetl(resetl), .start(sw_start), .abort(1'b0),
        .signed_mode(sw_sm), .a(sw_a), .b(sw_b), .busy(cw_busy),
        .done(cw_done), .gt(cw_gt), .eq(cw_eq), .lt(cw_lt)
    );

    function automatic logic [2:0] res();
        return {gt, eq, lt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv,
                          input logic sm);
        a = av;
        b = bv;
        signed_mode = sm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after the capture edge until done; 40 means timeout
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
            if (done) break;
        end
    endtask

    task automatic sweep_one(input logic [31:0] av, input logic [31:0] bv,
                             input logic sm);
        logic [2:0]  exp;
        logic [31:0] x;
        int          exp_lat, l1, lw, t;
        logic [2:0]  r1, rw;
        if (sm)
            exp = {$signed(av) > $signed(bv), av == bv, $signed(av) < $signed(bv)};
        else
            exp = {av > bv, av == bv, av < bv};
        x = av ^ bv;
        exp_lat = 32;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) begin
                exp_lat = 32 - i;
                break;
            end
        end
        sw_a = av;
        sw_b = bv;
        sw_sm = sm;
        sw_start = 1'b1;
        tick();
        sw_start = 1'b0;
        l1 = -1;
        lw = -1;
        r1 = '0;
        rw = '0;
        t = 0;
        while ((l1 < 0 || lw < 0) && t < 40) begin
            tick();
            t++;
            if (c1_done && l1 < 0) begin
                l1 = t;
                r1 = {c1_gt, c1_eq, c1_lt};
            end
            if (cw_done && lw < 0) begin
                lw = t;
                rw = {cw_gt, cw_eq, cw_lt};
            end
        end
        chk("c1_res", 32'(r1), 32'(exp));
        chk("c1_lat", l1, exp_lat);
        chk("cw_res", 32'(rw), 32'(exp));
        chk("cw_lat", lw, 1);
    endtask

    initial begin
        int lat, bcnt, cnt;

        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_res", 32'(res()), 0);
        #3 resetl = 1'b1;
        tick();

        // MSB slice decides immediately
        launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        wait_done(lat, bcnt);
        chk("t1_lat", lat, 1);
        chk("t1_res", 32'(res()), 32'b100);
        chk("t1_busy_done", 32'(busy), 0);
        tick();

        launch(32'h1234_5678, 32'h1234_5678, 1'b0);
        wait_done(lat, bcnt);
        chk("t2_lat", lat, 8);
        chk("t2_busycnt", bcnt, 8);
        chk("t2_res", 32'(res()), 32'b010);
        tick();
        chk("t2_done_pulse", 32'(done), 0);
        chk("t2_hold", 32'(res()), 32'b010);

        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done(lat, bcnt);
        chk("t3s_lat", lat, 1);
        chk("t3s_res", 32'(res()), 32'b001);
        tick();
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat, bcnt);
        chk("t3u_res", 32'(res()), 32'b100);
        tick();

        launch(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done(lat, bcnt);
        chk("t4_lat", lat, 7);
        chk("t4_res", 32'(res()), 32'b001);
        tick();

        // Abort at k+3 of a compare that would otherwise end eq
        launch(32'h5, 32'h5, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4a_busy", 32'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) cnt++;
            tick();
        end
        chk("t4a_nodone", cnt, 0);
        chk("t4a_hold", 32'(res()), 32'b001);

        // Abort alongside start in IDLE is ignored
        abort = 1'b1;
        launch(32'h3, 32'h1, 1'b0);
        abort = 1'b0;
        chk("t4b_busy", 32'(busy), 1);
        wait_done(lat, bcnt);
        chk("t4b_lat", lat, 8);
        chk("t4b_res", 32'(res()), 32'b100);
        tick();

        // start held high across three compares
        a = 32'h1;
        b = 32'h2;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        a = 32'hF000_0000;
        b = 32'h0;
        wait_done(lat, bcnt);
        chk("t5a_lat", lat, 8);
        chk("t5a_res", 32'(res()), 32'b001);
        chk("t5a_busy", 32'(busy), 0);
        tick();
        chk("t5b_nobubble", 32'(busy), 1);
        chk("t5b_pulse", 32'(done), 0);
        a = 32'hAAAA_5555;
        b = 32'hAAAA_5555;
        wait_done(lat, bcnt);
        chk("t5b_lat", lat, 1);
        chk("t5b_res", 32'(res()), 32'b100);
        tick();
        chk("t5c_nobubble", 32'(busy), 1);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("t5c_lat", lat, 8);
        chk("t5c_res", 32'(res()), 32'b010);
        tick();

        // Asynchronous reset in the middle of a compare
        launch(32'h7, 32'h7, 1'b0);
        tick();
        tick();
        resetl = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_res", 32'(res()), 0);
        tick();
        #3 resetl = 1'b1;
        tick();

        sweep_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        sweep_one(32'h0000_0001, 32'h0000_0000, 1'b0);
        sweep_one(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ (32'h1 << (i % 32))) : $urandom);
            sweep_one(ra, rb, i[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
